// File: rtl/pipe_stage_latch.sv
// Elastic inter-stage pipeline register: LANES x WIDTH payload under valid/ready,
// with an optional 2-entry skid buffer, flush, per-lane kill and bubble compaction.
module pipe_stage_latch #(
  parameter int WIDTH = 152,
  parameter int LANES = 2,
  parameter bit SKID  = 1'b1
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   ctrl_flush,
  input  logic [LANES-1:0]       ctrl_kill,
  output logic [1:0]             occupancy
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_SKID = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [LANES*WIDTH-1:0] headData_q, headData_d;
  logic [LANES*WIDTH-1:0] skidData_q, skidData_d;
  logic [LANES-1:0]       headLv_q, headLv_d;
  logic [LANES-1:0]       skidLv_q, skidLv_d;

  logic             inFire, outFire, bubble, storeFire;
  logic             killActive, killRetire, headGone;
  logic [LANES-1:0] killedLv;

  assign out_valid      = (state_q != EMPTY);
  assign out_lane_valid = headLv_q;
  assign out_data       = headData_q;

  assign inFire    = in_valid & in_ready;
  assign outFire   = out_valid & out_ready;
  assign bubble    = (in_lane_valid == '0);
  assign storeFire = inFire & ~bubble & ~ctrl_flush;

  // A kill that empties every lane retires the head exactly like a downstream fire.
  assign killedLv   = headLv_q & ~ctrl_kill;
  assign killActive = ~ctrl_flush & out_valid & ~outFire;
  assign killRetire = killActive & (killedLv == '0);
  assign headGone   = ~ctrl_flush & (outFire | killRetire);

  always_comb begin
    state_d    = state_q;
    headData_d = headData_q;
    skidData_d = skidData_q;
    headLv_d   = headLv_q;
    skidLv_d   = skidLv_q;

    if (ctrl_flush) begin
      state_d  = EMPTY;
      headLv_d = '0;
      skidLv_d = '0;
    end else begin
      if (killActive) begin
        headLv_d = killedLv;
      end

      unique case (state_q)
        EMPTY: begin
          if (storeFire) begin
            state_d    = FULL;
            headData_d = in_data;
            headLv_d   = in_lane_valid;
          end
        end
        FULL: begin
          if (headGone && storeFire) begin
            headData_d = in_data;
            headLv_d   = in_lane_valid;
          end else if (headGone) begin
            state_d  = EMPTY;
            headLv_d = '0;
          end else if (storeFire && SKID) begin
            state_d    = FULL_SKID;
            skidData_d = in_data;
            skidLv_d   = in_lane_valid;
          end
        end
        FULL_SKID: begin
          // in_ready is low here, so the only movement is skid -> head.
          if (headGone) begin
            state_d    = FULL;
            headData_d = skidData_q;
            headLv_d   = skidLv_q;
            skidLv_d   = '0;
          end
        end
        default: begin
          state_d  = EMPTY;
          headLv_d = '0;
          skidLv_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state_q    <= EMPTY;
      headData_q <= '0;
      skidData_q <= '0;
      headLv_q   <= '0;
      skidLv_q   <= '0;
    end else begin
      state_q    <= state_d;
      headData_q <= headData_d;
      skidData_q <= skidData_d;
      headLv_q   <= headLv_d;
      skidLv_q   <= skidLv_d;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY:     occupancy = 2'd0;
      FULL:      occupancy = 2'd1;
      FULL_SKID: occupancy = 2'd2;
      default:   occupancy = 2'd0;
    endcase
  end

  generate
    if (SKID) begin : gSkid
      // Registered ready: low in reset, then "not full next cycle".
      logic inReady_q;
      always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
          inReady_q <= 1'b0;
        end else begin
          inReady_q <= (state_d != FULL_SKID);
        end
      end
      assign in_ready = inReady_q;
    end else begin : gNoSkid
      assign in_ready = ctrl_reset & (~out_valid | out_ready);
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Self-checking bench for pipe_stage_latch: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pipe_stage_latch;

  localparam int WIDTH = 152;
  localparam int LANES = 2;
  localparam int DW    = LANES * WIDTH;

  logic             clock = 1'b0;
  logic             ctrl_reset;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_lane_valid;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_lane_valid;
  logic [DW-1:0]    out_data;
  logic             ctrl_flush;
  logic [LANES-1:0] ctrl_kill;
  logic [1:0]       occupancy;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic [LANES-1:0] lv;
    logic [DW-1:0]    data;
  } entry_t;

  entry_t mq[$];
  logic   rdyModel;

  logic [DW-1:0] patA, patB, patC, patD;

  pipe_stage_latch #(.WIDTH(WIDTH), .LANES(LANES), .SKID(1'b1)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_data       (out_data),
    .ctrl_flush     (ctrl_flush),
    .ctrl_kill      (ctrl_kill),
    .occupancy      (occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pattern(input logic [31:0] seed);
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = seed[i % 32] ^ (i % 3 == 0);
    return v;
  endfunction

  function automatic logic [DW-1:0] randPayload();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic [LANES-1:0] kl);
    in_valid      = v;
    in_lane_valid = lv;
    in_data       = d;
    out_ready     = ordy;
    ctrl_flush    = fl;
    ctrl_kill     = kl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    tick();
    checksTotal++;
    if ({in_ready, out_valid, occupancy, out_lane_valid} !== {1'b0, 1'b0, 2'd0, 2'b00} || out_data !== '0) begin
      $display("FAIL reset_state: rdy/vld/occ/lv=%b/%b/%0d/%b data=%h expected 0/0/0/00 data=0",
               in_ready, out_valid, occupancy, out_lane_valid, out_data);
    end else checksPassed++;

    drive(1'b1, 2'b11, patA, 1'b1, 1'b0, '0);
    ctrl_reset = 1'b1;
    tick();
    checksTotal++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL reset_release_ready: rdy/vld=%b%b expected 10", in_ready, out_valid);
    end else checksPassed++;

    tick();
    checksTotal++;
    if ({out_valid, occupancy, out_lane_valid} !== {1'b1, 2'd1, 2'b11} || out_data !== patA) begin
      $display("FAIL first_beat: vld/occ/lv=%b/%0d/%b data=%h expected 1/1/11 data=%h",
               out_valid, occupancy, out_lane_valid, out_data, patA);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
    tick();
    checksTotal++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      $display("FAIL first_beat_retire: vld/occ=%b/%0d expected 0/0", out_valid, occupancy);
    end else checksPassed++;
  endtask

  task automatic test_skid_order();
    drive(1'b1, 2'b11, patA, 1'b0, 1'b0, '0);
    tick();
    checksTotal++;
    if ({occupancy, in_ready} !== {2'd1, 1'b1} || out_data !== patA) begin
      $display("FAIL skid_after_A: occ/rdy=%0d/%b expected 1/1", occupancy, in_ready);
    end else checksPassed++;

    drive(1'b1, 2'b11, patB, 1'b0, 1'b0, '0);
    tick();
    checksTotal++;
    if ({occupancy, in_ready} !== {2'd2, 1'b0} || out_data !== patA) begin
      $display("FAIL skid_after_B: occ/rdy=%0d/%b head_is_A=%b expected 2/0/1",
               occupancy, in_ready, out_data === patA);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
    tick();
    checksTotal++;
    if ({occupancy, in_ready, out_valid} !== {2'd1, 1'b1, 1'b1} || out_data !== patB) begin
      $display("FAIL skid_A_retired: occ/rdy/vld=%0d/%b/%b head_is_B=%b expected 1/1/1/1",
               occupancy, in_ready, out_valid, out_data === patB);
    end else checksPassed++;

    tick();
    checksTotal++;
    if ({occupancy, out_valid} !== {2'd0, 1'b0}) begin
      $display("FAIL skid_B_retired: occ/vld=%0d/%b expected 0/0", occupancy, out_valid);
    end else checksPassed++;
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b11, patA, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 2'b01, patB, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 2'b11, patC, 1'b0, 1'b1, 2'b11);
    tick();
    checksTotal++;
    if ({out_valid, occupancy, in_ready, out_lane_valid} !== {1'b0, 2'd0, 1'b1, 2'b00}) begin
      $display("FAIL flush_empty: vld/occ/rdy/lv=%b/%0d/%b/%b expected 0/0/1/00",
               out_valid, occupancy, in_ready, out_lane_valid);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checksTotal++;
      if (out_valid !== 1'b0 || out_data === patC) begin
        $display("FAIL flush_no_C: vld=%b saw_C=%b expected 0/0", out_valid, out_data === patC);
      end else checksPassed++;
    end
  endtask

  task automatic test_kill();
    drive(1'b1, 2'b11, patA, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 2'b11, patB, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b10);
    tick();
    checksTotal++;
    if ({out_lane_valid, occupancy} !== {2'b01, 2'd2} || out_data !== patA) begin
      $display("FAIL kill_one_lane: lv/occ=%b/%0d head_is_A=%b expected 01/2/1",
               out_lane_valid, occupancy, out_data === patA);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b01);
    tick();
    checksTotal++;
    if ({out_lane_valid, occupancy, in_ready} !== {2'b11, 2'd1, 1'b1} || out_data !== patB) begin
      $display("FAIL kill_retire: lv/occ/rdy=%b/%0d/%b head_is_B=%b expected 11/1/1/1",
               out_lane_valid, occupancy, in_ready, out_data === patB);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b1, 1'b0, 2'b11);
    tick();
    checksTotal++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      $display("FAIL kill_ignored_on_fire: vld/occ=%b/%0d expected 0/0", out_valid, occupancy);
    end else checksPassed++;
  endtask

  task automatic test_bubble();
    drive(1'b1, 2'b00, patD, 1'b0, 1'b0, '0);
    checksTotal++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bubble_ready: rdy=%b expected 1", in_ready);
    end else checksPassed++;
    tick();
    checksTotal++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      $display("FAIL bubble_empty: vld/occ=%b/%0d expected 0/0", out_valid, occupancy);
    end else checksPassed++;

    drive(1'b1, 2'b10, patA, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 2'b00, patD, 1'b0, 1'b0, '0);
    tick();
    checksTotal++;
    if ({occupancy, in_ready, out_lane_valid} !== {2'd1, 1'b1, 2'b10} || out_data !== patA) begin
      $display("FAIL bubble_full: occ/rdy/lv=%0d/%b/%b expected 1/1/10", occupancy, in_ready, out_lane_valid);
    end else checksPassed++;

    drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b11, patA, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 2'b11, patB, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    #2;
    ctrl_reset = 1'b0;
    #1;
    checksTotal++;
    if ({out_valid, in_ready, occupancy, out_lane_valid} !== {1'b0, 1'b0, 2'd0, 2'b00} || out_data !== '0) begin
      $display("FAIL async_reset: vld/rdy/occ/lv=%b/%b/%0d/%b expected 0/0/0/00",
               out_valid, in_ready, occupancy, out_lane_valid);
    end else checksPassed++;
    tick();
    ctrl_reset = 1'b1;
    tick();
    checksTotal++;
    if ({out_valid, in_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      $display("FAIL async_reset_recover: vld/rdy/occ=%b/%b/%0d expected 0/1/0", out_valid, in_ready, occupancy);
    end else checksPassed++;
  endtask

  task automatic test_random();
    entry_t e;
    logic   inFireM, outFireM;
    mq.delete();
    rdyModel = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(($urandom_range(0, 9) < 7), LANES'($urandom_range(0, 3)), randPayload(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 9) == 0) ? LANES'($urandom_range(1, 3)) : '0);

      // Reference: a FIFO of at most two beats; kill trims the oldest beat.
      inFireM  = in_valid && rdyModel;
      outFireM = (mq.size() > 0) && out_ready;
      if (ctrl_flush) begin
        mq.delete();
      end else begin
        if (outFireM) begin
          void'(mq.pop_front());
        end else if (mq.size() > 0) begin
          mq[0].lv = mq[0].lv & ~ctrl_kill;
          if (mq[0].lv == '0) void'(mq.pop_front());
        end
        if (inFireM && in_lane_valid != '0) begin
          e.lv   = in_lane_valid;
          e.data = in_data;
          mq.push_back(e);
        end
      end
      rdyModel = (mq.size() < 2);

      tick();
      checksTotal++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) || in_ready !== rdyModel) begin
        $display("FAIL rand_ctrl cyc %0d: vld/occ/rdy=%b/%0d/%b expected %b/%0d/%b",
                 cyc, out_valid, occupancy, in_ready, mq.size() > 0, mq.size(), rdyModel);
      end else checksPassed++;
      if (mq.size() > 0) begin
        checksTotal++;
        if (out_lane_valid !== mq[0].lv || out_data !== mq[0].data) begin
          $display("FAIL rand_head cyc %0d: lv=%b data=%h expected lv=%b data=%h",
                   cyc, out_lane_valid, out_data, mq[0].lv, mq[0].data);
        end else checksPassed++;
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, '0);
    tick();
    tick();
  endtask

  initial begin
    patA = pattern(32'hA11C_E001);
    patB = pattern(32'hB0B0_1234);
    patC = pattern(32'hC0DE_7777);
    patD = pattern(32'hDEAD_BEEF);
    test_reset();
    test_skid_order();
    test_flush();
    test_kill();
    test_bubble();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
